// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory bus arbiter.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_e;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  // Address window [17:16] == 2'b11 selects the IO space (UART lives here).
  localparam logic [1:0] IO_ADDR_HI = 2'b11;
  localparam int         IO_HI_BIT  = 17;
  localparam int         IO_LO_BIT  = 16;

  localparam int LEN_W = 3;

endpackage

// File: rtl/mem_rr_arbiter.sv
// Combinational grant selection: fixed priority (lowest index) or
// round-robin starting the search at ptr_i. The pointer is owned by the parent.
module mem_rr_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 mode_i,
  input  logic [NUM_PORTS-1:0] eligible_i,
  input  logic [IDX_W-1:0]     ptr_i,
  output logic                 gnt_valid_o,
  output logic [IDX_W-1:0]     gnt_idx_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Scan from the far end so the last hit is the one closest to the start point.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (mode_i == ARB_RR) cand = (int'(ptr_i) + i) % NUM_PORTS;
      else                  cand = i;
      cand_idx = IDX_W'(cand);
      if (eligible_i[cand_idx]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Multi-port byte-serial memory controller: arbitrates requesters onto the 8-bit
// RAM/IO bus, serialises transfers into byte beats and assembles little-endian reads.
module mem_bus_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int                   NUM_PORTS  = 3,
  parameter int                   ADDR_W     = 32,
  parameter int                   MAX_BYTES  = 4,
  parameter int                   ARB_MODE   = 0,
  parameter logic [NUM_PORTS-1:0] FLUSH_MASK = {NUM_PORTS{1'b1}}
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rdy,
  input  logic                             flush,
  input  logic                             io_buffer_full,
  input  logic [7:0]                       mem_din,
  output logic [7:0]                       mem_dout,
  output logic [ADDR_W-1:0]                mem_a,
  output logic                             mem_wr,
  input  logic [NUM_PORTS-1:0]             req,
  input  logic [NUM_PORTS-1:0]             wr,
  input  logic [NUM_PORTS*ADDR_W-1:0]      addr,
  input  logic [NUM_PORTS*LEN_W-1:0]       len,
  input  logic [NUM_PORTS*8*MAX_BYTES-1:0] wdata,
  output logic [NUM_PORTS-1:0]             done,
  output logic [8*MAX_BYTES-1:0]           rdata,
  output state_e                           dbg_state
);

  localparam int   IDX_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int   CNT_W   = $clog2(MAX_BYTES + 2);
  localparam int   DATA_W  = 8 * MAX_BYTES;
  localparam logic ARB_SEL = (ARB_MODE == 1) ? ARB_RR : ARB_FIXED;

  state_e                 state_q;
  logic [IDX_W-1:0]       port_q;
  logic [IDX_W-1:0]       ptr_q;
  logic [ADDR_W-1:0]      start_q;
  logic [CNT_W-1:0]       len_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [DATA_W-1:0]      rdata_q;
  logic [ADDR_W-1:0]      mem_a_q;
  logic [7:0]             mem_dout_q;
  logic                   mem_wr_q;
  logic [NUM_PORTS-1:0]   done_q;

  logic [NUM_PORTS-1:0]   eligible_d;
  logic                   gnt_valid_d;
  logic [IDX_W-1:0]       gnt_idx_d;
  logic [ADDR_W-1:0]      g_addr_d;
  logic [CNT_W-1:0]       g_len_d;
  logic [DATA_W-1:0]      g_wdata_d;
  logic                   g_wr_d;
  logic [ADDR_W-1:0]      beat_addr_d;
  logic [DATA_W-1:0]      wshift_d;
  logic [ADDR_W-1:0]      stall_addr_d;
  logic                   io_stall_d;

  // Lengths of 0 or beyond the bus limit mean a full-width transfer.
  function automatic logic [CNT_W-1:0] eff_len(input logic [LEN_W-1:0] l);
    if (l == '0 || int'(l) > MAX_BYTES) return CNT_W'(MAX_BYTES);
    return CNT_W'(l);
  endfunction

  always_comb begin
    eligible_d   = req & ~done_q & ~(flush ? FLUSH_MASK : '0);
    g_addr_d     = addr[int'(gnt_idx_d)*ADDR_W +: ADDR_W];
    g_len_d      = eff_len(len[int'(gnt_idx_d)*LEN_W +: LEN_W]);
    g_wdata_d    = wdata[int'(gnt_idx_d)*DATA_W +: DATA_W];
    g_wr_d       = wr[gnt_idx_d];
    beat_addr_d  = start_q + ADDR_W'(cnt_q);
    wshift_d     = wdata_q >> (8 * int'(cnt_q));
    stall_addr_d = (state_q == IDLE) ? g_addr_d : beat_addr_d;
    io_stall_d   = io_buffer_full &&
                   (stall_addr_d[IO_HI_BIT:IO_LO_BIT] == IO_ADDR_HI);
  end

  mem_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_arb (
    .mode_i      (ARB_SEL),
    .eligible_i  (eligible_d),
    .ptr_i       (ptr_q),
    .gnt_valid_o (gnt_valid_d),
    .gnt_idx_o   (gnt_idx_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      port_q     <= '0;
      ptr_q      <= '0;
      start_q    <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      done_q     <= '0;
    end else if (rdy) begin
      done_q <= '0;
      case (state_q)
        IDLE: begin
          mem_a_q  <= '0;
          mem_wr_q <= 1'b0;
          if (gnt_valid_d) begin
            port_q  <= gnt_idx_d;
            start_q <= g_addr_d;
            len_q   <= g_len_d;
            wdata_q <= g_wdata_d;
            rdata_q <= '0;
            mem_a_q <= g_addr_d;
            if (ARB_SEL == ARB_RR)
              ptr_q <= (int'(gnt_idx_d) == NUM_PORTS - 1) ? '0 : gnt_idx_d + IDX_W'(1);
            if (g_wr_d) begin
              state_q    <= WRITE;
              mem_dout_q <= g_wdata_d[7:0];
              mem_wr_q   <= !io_stall_d;
              cnt_q      <= io_stall_d ? CNT_W'(0) : CNT_W'(1);
            end else begin
              state_q <= READ;
              cnt_q   <= CNT_W'(1);
            end
          end
        end

        // cnt_q counts edges since grant: it names the next address to issue,
        // and mem_din carries byte cnt_q-2 because the RAM answers one cycle late.
        READ: begin
          if (flush && FLUSH_MASK[port_q]) begin
            state_q <= IDLE;
            mem_a_q <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            for (int b = 0; b < MAX_BYTES; b++)
              if (cnt_q == CNT_W'(b + 2)) rdata_q[8*b +: 8] <= mem_din;
            mem_a_q <= (cnt_q < len_q) ? beat_addr_d : '0;
            if (cnt_q == len_q + CNT_W'(1)) begin
              done_q[port_q] <= 1'b1;
              state_q        <= IDLE;
            end
          end
        end

        // Here cnt_q counts beats already driven with mem_wr high.
        WRITE: begin
          if (cnt_q == len_q) begin
            mem_wr_q       <= 1'b0;
            mem_a_q        <= '0;
            done_q[port_q] <= 1'b1;
            state_q        <= IDLE;
          end else begin
            mem_a_q    <= beat_addr_d;
            mem_dout_q <= wshift_d[7:0];
            mem_wr_q   <= !io_stall_d;
            if (!io_stall_d) cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // While frozen the pending beat or pulse stays registered but is masked off the bus.
  assign mem_wr    = mem_wr_q & rdy;
  assign done      = done_q & {NUM_PORTS{rdy}};
  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign rdata     = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a fixed-priority and a round-robin instance
// share stimulus; each sees its own synchronous RAM model.
module tb_mem_bus_arbiter;
  import mem_ctrl_pkg::*;

  localparam int NP = 3;
  localparam int AW = 32;
  localparam int MB = 4;
  localparam int LW = 3;

  logic clk = 1'b0;
  logic rst, rdy, flush, io_full;
  logic [7:0]         mem_din, mem_din_rr, mem_dout, mem_dout_rr;
  logic [AW-1:0]      mem_a, mem_a_rr;
  logic               mem_wr, mem_wr_rr;
  logic [NP-1:0]      req, wr, done, done_rr;
  logic [NP*AW-1:0]   addr;
  logic [NP*LW-1:0]   len;
  logic [NP*8*MB-1:0] wdata;
  logic [8*MB-1:0]    rdata, rdata_rr;
  state_e             st, st_rr;

  logic [7:0]  ram [0:1023];
  logic [39:0] wr_log[$];
  logic [39:0] exp_q[$];
  logic [2:0]  seq_f[$];
  logic [2:0]  seq_r[$];
  int vectors = 0;
  int miscompares = 0;

  mem_bus_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .MAX_BYTES(MB), .ARB_MODE(0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .io_buffer_full(io_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .req(req), .wr(wr), .addr(addr), .len(len), .wdata(wdata),
    .done(done), .rdata(rdata), .dbg_state(st)
  );

  mem_bus_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .MAX_BYTES(MB), .ARB_MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .io_buffer_full(io_full),
    .mem_din(mem_din_rr), .mem_dout(mem_dout_rr), .mem_a(mem_a_rr), .mem_wr(mem_wr_rr),
    .req(req), .wr(wr), .addr(addr), .len(len), .wdata(wdata),
    .done(done_rr), .rdata(rdata_rr), .dbg_state(st_rr)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Synchronous RAM (one cycle read latency) frozen with the rest of the system.
  always @(posedge clk) begin
    if (rdy) begin
      mem_din    <= ram[mem_a[9:0]];
      mem_din_rr <= ram[mem_a_rr[9:0]];
    end
  end

  always @(posedge clk) if (mem_wr) wr_log.push_back({mem_a, mem_dout});

  // ---------------- driver tasks ----------------
  task automatic set_port(input int p, input logic w, input logic [AW-1:0] a,
                          input logic [LW-1:0] l, input logic [8*MB-1:0] d);
    wr[p]              = w;
    addr[p*AW +: AW]   = a;
    len[p*LW +: LW]    = l;
    wdata[p*8*MB +: 8*MB] = d;
    req[p]             = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output logic [NP-1:0] seen, output int cyc);
    int k;
    k    = 0;
    seen = '0;
    cyc  = 0;
    while (seen == '0 && k < max_cyc) begin
      @(negedge clk);
      k++;
      if (done !== '0) begin
        seen = done;
        cyc  = k;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    vectors++; if (mem_a !== '0)     begin miscompares++; $display("FAIL rst_mem_a: got %h want 0", mem_a); end
    vectors++; if (mem_dout !== '0)  begin miscompares++; $display("FAIL rst_mem_dout: got %h want 0", mem_dout); end
    vectors++; if (mem_wr !== 1'b0)  begin miscompares++; $display("FAIL rst_mem_wr: got %b want 0", mem_wr); end
    vectors++; if (done !== '0)      begin miscompares++; $display("FAIL rst_done: got %b want 0", done); end
    vectors++; if (rdata !== '0)     begin miscompares++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    vectors++; if (st !== IDLE)      begin miscompares++; $display("FAIL rst_state: got %0d want IDLE", st); end
    vectors++; if (st_rr !== IDLE)   begin miscompares++; $display("FAIL rst_state_rr: got %0d want IDLE", st_rr); end
    rst = 1'b0;
  endtask

  task automatic test_read4();
    logic [AW-1:0] ea;
    logic [NP-1:0] ed;
    @(negedge clk);
    set_port(1, 1'b0, 32'h100, 3'd4, '0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      ea = (k <= 4) ? 32'h100 + AW'(k - 1) : '0;
      ed = (k == 6) ? 3'b010 : 3'b000;
      vectors++; if (mem_a !== ea) begin miscompares++; $display("FAIL read4_addr c%0d: got %h want %h", k, mem_a, ea); end
      vectors++; if (done !== ed)  begin miscompares++; $display("FAIL read4_done c%0d: got %b want %b", k, done, ed); end
      if (k == 6) begin
        vectors++; if (rdata !== 32'h0000_0513) begin miscompares++; $display("FAIL read4_rdata: got %h want 00000513", rdata); end
        req[1] = 1'b0;
      end
    end
    @(negedge clk);
    vectors++; if (done !== '0) begin miscompares++; $display("FAIL read4_done_pulse: got %b want 000", done); end
  endtask

  task automatic test_fixed_priority();
    logic [NP-1:0] seen;
    int cyc;
    do_reset();
    set_port(0, 1'b0, 32'h10, 3'd1, '0);
    set_port(2, 1'b0, 32'h20, 3'd1, '0);
    wait_done(10, seen, cyc);
    vectors++; if (seen !== 3'b001) begin miscompares++; $display("FAIL fixed_first: got %b want 001", seen); end
    vectors++; if (cyc != 3)        begin miscompares++; $display("FAIL fixed_first_lat: got %0d want 3", cyc); end
    req[0] = 1'b0;
    wait_done(10, seen, cyc);
    vectors++; if (seen !== 3'b100) begin miscompares++; $display("FAIL fixed_second: got %b want 100", seen); end
    vectors++; if (cyc != 3)        begin miscompares++; $display("FAIL fixed_second_lat: got %0d want 3", cyc); end
    vectors++; if (rdata !== {24'h0, ram[10'h20]}) begin miscompares++; $display("FAIL fixed_rdata: got %h want %h", rdata, {24'h0, ram[10'h20]}); end
    req[2] = 1'b0;
  endtask

  task automatic collect(input int n);
    seq_f.delete();
    seq_r.delete();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (done !== '0)    seq_f.push_back(done);
      if (done_rr !== '0) seq_r.push_back(done_rr);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_f [4];
    logic [2:0] exp_r [4];
    logic [2:0] got;
    exp_f = '{3'b001, 3'b010, 3'b001, 3'b010};
    exp_r = '{3'b001, 3'b010, 3'b100, 3'b001};
    do_reset();
    set_port(0, 1'b0, 32'h10, 3'd1, '0);
    set_port(1, 1'b0, 32'h14, 3'd1, '0);
    set_port(2, 1'b0, 32'h18, 3'd1, '0);
    collect(13);
    for (int i = 0; i < 4; i++) begin
      got = (i < seq_f.size()) ? seq_f[i] : 3'b000;
      vectors++; if (got !== exp_f[i]) begin miscompares++; $display("FAIL held3_fixed[%0d]: got %b want %b", i, got, exp_f[i]); end
      got = (i < seq_r.size()) ? seq_r[i] : 3'b000;
      vectors++; if (got !== exp_r[i]) begin miscompares++; $display("FAIL held3_rr[%0d]: got %b want %b", i, got, exp_r[i]); end
    end
    exp_r = '{3'b001, 3'b100, 3'b001, 3'b100};
    do_reset();
    set_port(0, 1'b0, 32'h10, 3'd1, '0);
    set_port(2, 1'b0, 32'h20, 3'd1, '0);
    collect(13);
    for (int i = 0; i < 4; i++) begin
      got = (i < seq_r.size()) ? seq_r[i] : 3'b000;
      vectors++; if (got !== exp_r[i]) begin miscompares++; $display("FAIL rr_0_2[%0d]: got %b want %b", i, got, exp_r[i]); end
    end
    do_reset();
  endtask

  task automatic test_io_stall();
    logic en_wr;
    logic [NP-1:0] ed;
    wr_log.delete();
    @(negedge clk);
    io_full = 1'b1;
    set_port(0, 1'b1, 32'h0003_0000, 3'd1, 32'h41);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      en_wr = (k == 4);
      ed    = (k == 5) ? 3'b001 : 3'b000;
      vectors++; if (mem_wr !== en_wr) begin miscompares++; $display("FAIL io_wr c%0d: got %b want %b", k, mem_wr, en_wr); end
      vectors++; if (done !== ed)      begin miscompares++; $display("FAIL io_done c%0d: got %b want %b", k, done, ed); end
      if (k == 4) begin
        vectors++; if ({mem_a, mem_dout} !== {32'h0003_0000, 8'h41}) begin miscompares++; $display("FAIL io_beat: got %h/%h want 00030000/41", mem_a, mem_dout); end
      end
      if (k == 3) io_full = 1'b0;
      if (k == 5) req[0] = 1'b0;
    end
    vectors++; if (wr_log.size() != 1) begin miscompares++; $display("FAIL io_beats: got %0d want 1", wr_log.size()); end
  endtask

  task automatic test_flush();
    logic [NP-1:0] seen;
    int cyc;
    @(negedge clk);
    set_port(0, 1'b0, 32'h200, 3'd2, '0);
    @(negedge clk);
    @(negedge clk);
    vectors++; if (mem_a !== 32'h201) begin miscompares++; $display("FAIL flush_rd_beat2: got %h want 201", mem_a); end
    flush = 1'b1;
    @(negedge clk);
    vectors++; if (mem_a !== '0) begin miscompares++; $display("FAIL flush_rd_addr: got %h want 0", mem_a); end
    vectors++; if (st !== IDLE)  begin miscompares++; $display("FAIL flush_rd_state: got %0d want IDLE", st); end
    flush  = 1'b0;
    req[0] = 1'b0;
    wait_done(4, seen, cyc);
    vectors++; if (seen !== '0) begin miscompares++; $display("FAIL flush_rd_nodone: got %b want 000", seen); end

    wr_log.delete();
    exp_q.delete();
    exp_q.push_back({32'hFFFF_FFFF, 8'hAA});
    exp_q.push_back({32'h0000_0000, 8'hBB});
    @(negedge clk);
    set_port(0, 1'b1, 32'hFFFF_FFFF, 3'd2, 32'h0000_BBAA);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    vectors++; if (done !== 3'b001) begin miscompares++; $display("FAIL flush_wr_done: got %b want 001", done); end
    flush  = 1'b0;
    req[0] = 1'b0;
    vectors++; if (wr_log.size() != exp_q.size()) begin miscompares++; $display("FAIL flush_wr_beats: got %0d want %0d", wr_log.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
      vectors++; if (wr_log[i] !== exp_q[i]) begin miscompares++; $display("FAIL flush_wr_beat[%0d]: got %h want %h", i, wr_log[i], exp_q[i]); end
    end
  endtask

  task automatic test_rdy_freeze();
    logic [NP-1:0] seen;
    int cyc;
    wr_log.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back({32'h400 + AW'(i), 8'(8'h11 * (i + 1))});
    @(negedge clk);
    set_port(2, 1'b1, 32'h400, 3'd0, 32'h4433_2211);
    @(negedge clk);
    vectors++; if ({mem_wr, mem_a} !== {1'b1, 32'h400}) begin miscompares++; $display("FAIL rdy_beat0: got %b/%h want 1/400", mem_wr, mem_a); end
    @(negedge clk);
    vectors++; if ({mem_wr, mem_a} !== {1'b1, 32'h401}) begin miscompares++; $display("FAIL rdy_beat1: got %b/%h want 1/401", mem_wr, mem_a); end
    rdy = 1'b0;
    for (int k = 3; k <= 6; k++) begin
      @(negedge clk);
      vectors++; if ({mem_wr, mem_a, done} !== {1'b0, 32'h401, 3'b000}) begin miscompares++; $display("FAIL rdy_frozen c%0d: got %b/%h/%b want 0/401/000", k, mem_wr, mem_a, done); end
    end
    rdy = 1'b1;
    wait_done(10, seen, cyc);
    vectors++; if (seen !== 3'b100) begin miscompares++; $display("FAIL rdy_done: got %b want 100", seen); end
    vectors++; if (cyc != 3)        begin miscompares++; $display("FAIL rdy_done_lat: got %0d want 3", cyc); end
    req[2] = 1'b0;
    vectors++; if (wr_log.size() != exp_q.size()) begin miscompares++; $display("FAIL rdy_beats: got %0d want %0d", wr_log.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
      vectors++; if (wr_log[i] !== exp_q[i]) begin miscompares++; $display("FAIL rdy_beat[%0d]: got %h want %h", i, wr_log[i], exp_q[i]); end
    end
  endtask

  task automatic test_async_reset();
    logic [NP-1:0] seen;
    int cyc;
    @(negedge clk);
    set_port(1, 1'b0, 32'h100, 3'd4, '0);
    @(negedge clk);
    @(negedge clk);
    vectors++; if (mem_a !== 32'h101) begin miscompares++; $display("FAIL arst_pre: got %h want 101", mem_a); end
    #2 rst = 1'b1;
    #1;
    vectors++; if ({mem_a, mem_dout, mem_wr, done} !== '0) begin miscompares++; $display("FAIL arst_outs: got %h/%h/%b/%b want 0", mem_a, mem_dout, mem_wr, done); end
    vectors++; if (rdata !== '0) begin miscompares++; $display("FAIL arst_rdata: got %h want 0", rdata); end
    vectors++; if (st !== IDLE)  begin miscompares++; $display("FAIL arst_state: got %0d want IDLE", st); end
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    set_port(1, 1'b0, 32'h100, 3'd4, '0);
    wait_done(12, seen, cyc);
    vectors++; if (seen !== 3'b010)         begin miscompares++; $display("FAIL arst_after_done: got %b want 010", seen); end
    vectors++; if (cyc != 6)                begin miscompares++; $display("FAIL arst_after_lat: got %0d want 6", cyc); end
    vectors++; if (rdata !== 32'h0000_0513) begin miscompares++; $display("FAIL arst_after_rdata: got %h want 00000513", rdata); end
    req[1] = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i) ^ 8'hA5;
    ram[10'h100] = 8'h13;
    ram[10'h101] = 8'h05;
    ram[10'h102] = 8'h00;
    ram[10'h103] = 8'h00;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_full = 1'b0;
    req = '0; wr = '0; addr = '0; len = '0; wdata = '0;
    @(negedge clk);
    test_reset();
    test_read4();
    test_fixed_priority();
    test_round_robin();
    test_io_stall();
    test_flush();
    test_rdy_freeze();
    test_async_reset();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
